itof_pipe: RTL

- Pipelined, parametrised integer-to-single-precision converter for the FPU; successor to the combinational fixed-32-bit signed itof.
- Adds per-op signed/unsigned mode, RNE/RTZ rounding, exact zero handling, configurable input width and valid/ready backpressure.
- Sits between the FPU issue stage and the FPU writeback arbiter.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/lzc_norm.sv | 30 +++
 rtl/itof_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// fpu_pkg : FP32 field widths, rounding-mode encodings and canonical constants
// Revision : 1.0
// ============================================================================
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rmode_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/lzc_norm.sv
`default_nettype none
// ============================================================================
// lzc_norm : leading-one detector plus left normaliser (combinational)
// Revision : 1.0
// ============================================================================
module lzc_norm #(
  parameter int WIDTH = 32,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [PW-1:0]    pos_o,
  output logic [WIDTH-1:0] norm_o,
  output logic             zero_o
);

  logic [PW-1:0] shamt;

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) pos_o = PW'(i);
    end
  end

  assign zero_o = ~|in_i;
  assign shamt  = PW'(WIDTH - 1) - pos_o;
  assign norm_o = in_i << shamt;

endmodule
`default_nettype wire

// File: rtl/itof_pipe.sv
`default_nettype none
// ============================================================================
// itof_pipe : 3-stage integer to FP32 converter, valid/ready, RNE/RTZ
//             Optional out_inexact flag when ITOF_PIPE_INEXACT_EN is defined
// Revision  : 1.0
// ============================================================================
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_signed,
  input  logic                 in_rtz,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef ITOF_PIPE_INEXACT_EN
  ,
  output logic                 out_inexact
`endif
);

  localparam int PW    = $clog2(IN_WIDTH);
  localparam int SIG_W = MAN_W + 1;

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv   = ~out_valid_q | out_ready;
  assign s2_adv   = ~s2_valid_q | s3_adv;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    if (s1_adv) s1_valid_d  = in_valid;
    if (s2_adv) s2_valid_d  = s1_valid_q;
    if (s3_adv) out_valid_d = s2_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // S1: sign and magnitude; -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  logic                 s1_sign_d, s1_sign_q;
  logic [IN_WIDTH-1:0]  s1_mag_d, s1_mag_q;
  rmode_e               s1_rm_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;

  assign s1_sign_d = in_signed & in_data[IN_WIDTH-1];
  assign s1_mag_d  = s1_sign_d ? (-in_data) : in_data;

  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_rm_q   <= in_rtz ? RM_RTZ : RM_RNE;
      s1_tag_q  <= in_tag;
    end
  end

  logic [PW-1:0]        w_pos;
  logic [IN_WIDTH-1:0]  w_norm;
  logic                 w_zero;

  lzc_norm #(.WIDTH(IN_WIDTH), .PW(PW)) u_lzc (
    .in_i   (s1_mag_q),
    .pos_o  (w_pos),
    .norm_o (w_norm),
    .zero_o (w_zero)
  );

  logic                 s2_sign_q, s2_zero_q;
  logic [PW-1:0]        s2_pos_q;
  logic [IN_WIDTH-1:0]  s2_norm_q;
  rmode_e               s2_rm_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;

  always_ff @(posedge clk) begin
    if (s2_adv) begin
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= w_zero;
      s2_pos_q  <= w_pos;
      s2_norm_q <= w_norm;
      s2_rm_q   <= s1_rm_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

  logic [SIG_W-1:0] w_sig;
  logic             w_guard, w_sticky;

  if (IN_WIDTH >= SIG_W + 2) begin : g_wide
    assign w_sig    = s2_norm_q[IN_WIDTH-1 -: SIG_W];
    assign w_guard  = s2_norm_q[IN_WIDTH-SIG_W-1];
    assign w_sticky = |s2_norm_q[IN_WIDTH-SIG_W-2:0];
  end else if (IN_WIDTH == SIG_W + 1) begin : g_guard_only
    assign w_sig    = s2_norm_q[IN_WIDTH-1:1];
    assign w_guard  = s2_norm_q[0];
    assign w_sticky = 1'b0;
  end else begin : g_exact
    assign w_sig    = SIG_W'(s2_norm_q) << (SIG_W - IN_WIDTH);
    assign w_guard  = 1'b0;
    assign w_sticky = 1'b0;
  end

  logic             w_inc;
  logic [SIG_W:0]   w_sum;
  logic [EXP_W-1:0] w_exp;
  logic [31:0]      w_result;

  assign w_inc = (s2_rm_q == RM_RNE) & w_guard & (w_sticky | w_sig[0]);
  assign w_sum = {1'b0, w_sig} + {{SIG_W{1'b0}}, w_inc};
  // Top two sum bits are 01 normally or 10 on carry, so adding them to BIAS-1 gives BIAS(+carry).
  assign w_exp    = EXP_W'(s2_pos_q) + EXP_W'(BIAS - 1) + EXP_W'(w_sum[SIG_W:SIG_W-1]);
  assign w_result = s2_zero_q ? FP32_ZERO : {s2_sign_q, w_exp, w_sum[MAN_W-1:0]};

  logic [31:0]          out_data_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  always_ff @(posedge clk) begin
    if (s3_adv) begin
      out_data_q <= w_result;
      out_tag_q  <= s2_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef ITOF_PIPE_INEXACT_EN
  logic inexact_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_q <= 1'b0;
    end else if (s3_adv) begin
      inexact_q <= w_guard | w_sticky;
    end
  end

  assign out_inexact = inexact_q;
`else
  // Default build carries no inexact state.
`endif

endmodule
`default_nettype wire
